// File: rtl/px_pkg.sv
// rtl/px_pkg.sv - shared FSM states, mode type and default rates for px_ce_gen
package px_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SWITCH = 2'd1,
    ST_SETTLE = 2'd2
  } px_state_e;

  typedef logic [1:0] px_mode_t;

  localparam int unsigned PX_ACC_W      = 16;
  localparam int unsigned PX_SETTLE_DEF = 16;

  // Increments are f_px / f_sys x 2^16 with a 50 MHz sys_clk.
  localparam int unsigned PX_INC_M0 = 32768;  // 25.000 MHz: 0.5    x 65536
  localparam int unsigned PX_INC_M1 = 21845;  // 16.667 MHz: 0.3333 x 65536, truncated
  localparam int unsigned PX_INC_M2 = 65536;  // 50.000 MHz: 1.0    x 65536, every cycle
  localparam int unsigned PX_INC_M3 = 16384;  // 12.500 MHz: 0.25   x 65536

endpackage

// File: rtl/phase_acc.sv
// rtl/phase_acc.sv - phase accumulator whose registered carry is the pixel clock-enable
module phase_acc
  import px_pkg::*;
#(
  parameter int unsigned    ACC_W   = PX_ACC_W,
  parameter logic [ACC_W:0] INC_RST = '0
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [ACC_W:0]   inc_in,
  input  logic             adv,
  output logic             px_ce
);

  // Only the fraction is stored; the carry bit lives in px_ce_q.
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   inc_q, inc_d;
  logic [ACC_W:0]   acc_sum;
  logic             px_ce_q, px_ce_d;

  always_comb begin
    acc_sum = {1'b0, acc_q} + inc_q;
    acc_d   = acc_q;
    inc_d   = inc_q;
    px_ce_d = 1'b0;
    if (clr) begin
      acc_d = '0;
    end
    if (load) begin
      inc_d = inc_in;
    end
    if (adv) begin
      acc_d   = acc_sum[ACC_W-1:0];
      px_ce_d = acc_sum[ACC_W];
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      inc_q   <= INC_RST;
      px_ce_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      inc_q   <= inc_d;
      px_ce_q <= px_ce_d;
    end
  end

  assign px_ce = px_ce_q;

endmodule

// File: rtl/px_ce_gen.sv
// rtl/px_ce_gen.sv - pixel clock-enable generator: mode FSM, settle timer, optional ce_count (PXCEGEN_COUNT_EN)
module px_ce_gen
  import px_pkg::*;
#(
  parameter int unsigned ACC_W      = PX_ACC_W,
  parameter int unsigned INC0       = PX_INC_M0,
  parameter int unsigned INC1       = PX_INC_M1,
  parameter int unsigned INC2       = PX_INC_M2,
  parameter int unsigned INC3       = PX_INC_M3,
  parameter int unsigned SETTLE_CYC = PX_SETTLE_DEF
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [1:0]  mode_sel,
  input  logic        mode_req,
  output logic        mode_ack,
  output logic [1:0]  cur_mode,
  output logic        px_ce,
  output logic        locked
`ifdef PXCEGEN_COUNT_EN
  ,
  output logic [31:0] ce_count
`endif
);

  localparam longint unsigned INC_MAX = 64'd1 << ACC_W;

  if (INC0 > INC_MAX || INC1 > INC_MAX || INC2 > INC_MAX || INC3 > INC_MAX) begin : g_bad_inc
    $error("px_ce_gen: an INCn parameter exceeds 2^ACC_W");
  end
  if (SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_bad_settle
    $error("px_ce_gen: SETTLE_CYC must be 1..255");
  end

  localparam logic [ACC_W:0] INC0_W      = INC0[ACC_W:0];
  localparam logic [ACC_W:0] INC1_W      = INC1[ACC_W:0];
  localparam logic [ACC_W:0] INC2_W      = INC2[ACC_W:0];
  localparam logic [ACC_W:0] INC3_W      = INC3[ACC_W:0];
  localparam logic [7:0]     SETTLE_LAST = 8'(SETTLE_CYC - 1);

  px_state_e      state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  px_mode_t       cur_mode_q, cur_mode_d;
  logic           pend_q, pend_d;
  logic           ack_q, ack_d;
  logic           locked_q, locked_d;
  logic [ACC_W:0] inc_sel;
  logic           acc_adv;
  logic           in_switch;

  always_comb begin
    inc_sel = INC0_W;
    case (cur_mode_q)
      2'd0:    inc_sel = INC0_W;
      2'd1:    inc_sel = INC1_W;
      2'd2:    inc_sel = INC2_W;
      default: inc_sel = INC3_W;
    endcase
  end

  // pend_q marks a settle started by a request, so only that settle acks.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_mode_d = cur_mode_q;
    pend_d     = pend_q;
    ack_d      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mode_req) begin
          if (mode_sel != cur_mode_q) begin
            state_d    = ST_SWITCH;
            cur_mode_d = mode_sel;
          end else begin
            ack_d = 1'b1;
          end
        end
      end
      ST_SWITCH: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
        pend_d  = 1'b1;
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          ack_d   = pend_q;
          pend_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
    endcase
    locked_d = (state_d == ST_RUN);
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_SETTLE;
      cnt_q      <= '0;
      cur_mode_q <= 2'd0;
      pend_q     <= 1'b0;
      ack_q      <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_mode_q <= cur_mode_d;
      pend_q     <= pend_d;
      ack_q      <= ack_d;
      locked_q   <= locked_d;
    end
  end

  // Advancing only while staying in RUN forces px_ce low on the SWITCH cycle.
  assign acc_adv   = (state_q == ST_RUN) && (state_d == ST_RUN);
  assign in_switch = (state_q == ST_SWITCH);

  phase_acc #(
    .ACC_W   (ACC_W),
    .INC_RST (INC0_W)
  ) u_phase_acc (
    .sys_clk (sys_clk),
    .reset   (reset),
    .clr     (in_switch),
    .load    (in_switch),
    .inc_in  (inc_sel),
    .adv     (acc_adv),
    .px_ce   (px_ce)
  );

  assign mode_ack = ack_q;
  assign cur_mode = cur_mode_q;
  assign locked   = locked_q;

`ifdef PXCEGEN_COUNT_EN
  logic [31:0] ce_count_q, ce_count_d;

  always_comb begin
    ce_count_d = ce_count_q + {31'd0, px_ce};
    if (in_switch) begin
      ce_count_d = '0;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      ce_count_q <= '0;
    end else begin
      ce_count_q <= ce_count_d;
    end
  end

  assign ce_count = ce_count_q;
`endif

endmodule

// File: doc/px_ce_gen.md
# px_ce_gen

Parametrised pixel-timing generator that replaces the fixed-ratio pixel clock stage. The design runs on a single `sys_clk` domain, so no PLL output clock is used. The block derives a pixel clock-enable pulse train from `sys_clk` with a phase accumulator. It switches at runtime between up to four video-mode rates through a request/acknowledge handshake and flags `locked` once the new rate is stable. It sits between the board clock input and the VGA sync/timing generator, which advances only on `px_ce`.

## Interface
Parameters:
- `ACC_W`, 16: accumulator fraction width; the rate resolution is 2^-ACC_W of `sys_clk`.
- `INC0`, 32768: mode-0 increment (ACC_W+1 bits); rate = INCn/2^ACC_W × f_sys.
- `INC1`, 21845: mode-1 increment.
- `INC2`, 65536: mode-2 increment (enable every cycle).
- `INC3`, 16384: mode-3 increment.
- `SETTLE_CYC`, 16: cycles held unlocked after reset or a mode switch; 1..255.

Ports:
- `sys_clk` in 1: system clock; the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `mode_sel` in 2: requested mode index; sampled only when `mode_req`=1.
- `mode_req` in 1: single-cycle request to switch mode.
- `mode_ack` out 1: single-cycle pulse when a requested switch completes.
- `cur_mode` out 2: mode currently in effect.
- `px_ce` out 1: pixel clock-enable, one `sys_clk` cycle wide.
- `locked` out 1: high while in RUN (rate valid).
- `ce_count` out 32: only when `PXCEGEN_COUNT_EN` is defined; see Configuration.

## Operation
- Accumulator `acc` is ACC_W+1 bits. In RUN, each cycle `acc <= {1'b0, acc[ACC_W-1:0]} + inc`, and `px_ce <= acc_next[ACC_W]` (registered carry).
- Any INCn > 2^ACC_W is a configuration error; the block asserts on it at elaboration. INCn = 0 gives no pulses in that mode; `locked` still rises.
- FSM states:
  - RUN: normal operation.
    - `mode_req`=1 with `mode_sel` ≠ `cur_mode`: go to SWITCH.
    - `mode_req`=1 with `mode_sel` = `cur_mode`: `mode_ack` pulses next cycle and the state stays RUN; the accumulator is undisturbed.
  - SWITCH (1 cycle): latch `cur_mode` and `inc`, clear `acc`, `px_ce`=0, `locked`=0. Go to SETTLE.
  - SETTLE: count SETTLE_CYC cycles with `px_ce`=0 and `locked`=0, then go to RUN. `mode_ack` pulses on the cycle `locked` rises, if the settle followed a request.
- `mode_req` in SWITCH or SETTLE is ignored; no ack is given. The requester waits for `locked` before requesting.
- Reset values: state SETTLE, `cur_mode`=0, `inc`=INC0, `acc`=0, settle counter=0, `px_ce`=0, `locked`=0, `mode_ack`=0, `ce_count`=0.
- Post-reset settle completion raises `locked` but gives no `mode_ack`.
- Reset asserted mid-switch or mid-settle returns all state to reset values immediately, without waiting for `sys_clk`.

## Timing
- `mode_req` at cycle T (different mode):
  - SWITCH at T+1.
  - SETTLE for cycles T+2 .. T+1+SETTLE_CYC.
  - RUN, `locked`=1 and `mode_ack`=1 at T+2+SETTLE_CYC.
- First `px_ce` at T+2+SETTLE_CYC+ceil(2^ACC_W/inc). For INC0 this is at +2.
- Same-mode `mode_req` at T: `mode_ack` at T+1, and the `px_ce` pattern is unbroken.
- Long-run pulse count over N RUN cycles = floor(N×inc/2^ACC_W) from `acc`=0. Pulses are never adjacent unless inc > 2^(ACC_W-1).
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `PXCEGEN_COUNT_EN` defined: the `ce_count` port exists. It is a 32-bit counter incremented on every `px_ce` and cleared at SWITCH and at reset. It wraps at 2^32 to 0 silently.
- `PXCEGEN_COUNT_EN` undefined: no port and no counter logic. All other behaviour is identical.

## Structure
- Shared package `px_pkg` holds:
  - the FSM state enum (RUN, SWITCH, SETTLE);
  - the mode index type (2 bits);
  - the default increment constants for the team's standard modes, with a derivation comment per mode (f_px/f_sys × 2^16).
- One sub-module is natural: `phase_acc`, the accumulator plus carry register with clear and load-increment inputs. The FSM, settle counter and optional counter stay in the top.

## Test plan
- Reset then release: `locked`=0 for 16 cycles, then `locked`=1 with no `mode_ack`. Mode 0 then gives `px_ce` on every second cycle, 50 pulses in 100 cycles.
- `mode_sel`=1 with `mode_req` at T: `locked` drops at T+1 and `mode_ack` and `locked` rise at T+18. Exactly 21845 pulses follow in the next 65536 cycles.
- `mode_sel`=2: `px_ce` is high on every cycle in RUN. Then `mode_sel`=3: one pulse per 4 cycles.
- Same-mode request in RUN: `mode_ack` on the next cycle and no gap in the `px_ce` pattern. A request during SETTLE gives no ack and `cur_mode` is unchanged.
- Reset asserted mid-SETTLE after a switch to mode 3: outputs clear asynchronously, `cur_mode` returns to 0, and the post-reset settle runs in full.
- With `PXCEGEN_COUNT_EN`, mode 0 for 200 RUN cycles: `ce_count`=100. It clears to 0 on the next switch.
